// File: rtl/mult_iter_16b_pkg.sv
// rtl/mult_iter_16b_pkg.sv - shared state encoding and default width for the iterative multiplier
package mult_iter_16b_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mult_iter_16b_if.sv
// rtl/mult_iter_16b_if.sv - operand/product handshake bundle for mult_iter_16b
import mult_iter_16b_pkg::*;

interface mult_iter_16b_if #(parameter int WIDTH = DEFAULT_WIDTH);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/mult_iter_16b_rca_nb.sv
// rtl/mult_iter_16b_rca_nb.sv - N-bit ripple-carry adder built from a chain of full-adder cells
module rca_nb #(
  parameter int N = 32
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  // Each cell keeps its own carry net so the chain is not one self-referencing vector.
  for (genvar i = 0; i < N; i++) begin : g_fa
    logic ci;
    logic co;
    if (i == 0) begin : g_first
      assign ci = cin;
    end else begin : g_next
      assign ci = g_fa[i-1].co;
    end
    assign sum[i] = x[i] ^ y[i] ^ ci;
    assign co     = (x[i] & y[i]) | (ci & (x[i] ^ y[i]));
  end

  assign cout = g_fa[N-1].co;

endmodule

// File: rtl/mult_iter_16b.sv
// rtl/mult_iter_16b.sv - iterative unsigned shift-add multiplier; MULT_EARLY_TERM_EN stops once remaining multiplier bits are zero
import mult_iter_16b_pkg::*;

module mult_iter_16b #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  mult_iter_16b_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_nx;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    sum;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last_iter;

  assign addend = mplier[0] ? mcand : '0;

  // Carry-out cannot be set for an exact product, so it is left open.
  rca_nb #(.N(PW)) u_add (
    .x    (acc),
    .y    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout ()
  );

`ifdef MULT_EARLY_TERM_EN
  assign last_iter = (mplier[WIDTH-1:1] == '0) || (cnt == CW'(WIDTH - 1));
`else
  assign last_iter = (cnt == CW'(WIDTH - 1));
`endif

  assign accept        = bus.in_valid && (state == IDLE);
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == RUN) || (state == DONE);
  assign bus.product   = acc;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nx = RUN;
      RUN:     if (last_iter)     state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, bus.a};
      mplier <= bus.b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc    <= sum;
      mcand  <= {mcand[PW-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
      cnt    <= cnt + 1'b1;
    end
  end

endmodule
